instruction_fetch: RTL and testbench

//   MIPS IF stage plus IF/ID pipeline register, directly upstream of the decode stage.
//   - Holds the PC and issues fetches to instruction memory with a req/ready handshake.
//   - Drives instruction32 and pcPlus4 into decode; supports stall and branch redirect.
//   - Holds one fetched word in a skid entry while decode is stalled.

---
 rtl/mips_pkg.sv | 17 +
 rtl/fetch_skid_buf.sv | 38 +++
 rtl/instruction_fetch.sv | 114 +++++++++++
 tb/tb_instruction_fetch.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: J opcode, default NOP word, fetch FSM encoding.
package mips_pkg;

   localparam logic [5:0]  OP_J          = 6'b000010;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;   // sll $0,$0,0

   typedef enum logic {
      FS_REQ  = 1'b0,
      FS_HOLD = 1'b1
   } fetch_state_e;

   // Word-align an address; fetch addresses never carry byte offsets.
   function automatic logic [31:0] word_align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid holding a fetched word while decode is stalled.
// clear has priority over load, load over drain.
module fetch_skid_buf (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        load_i,
   input  logic        drain_i,
   input  logic        clear_i,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_plus4_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_plus4_o,
   output logic        valid_o
);

   logic [31:0] instr_q, pc_plus4_q;
   logic        valid_q;

   // Capture on load, invalidate on drain, clear or reset.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i || clear_i) begin
         instr_q    <= '0;
         pc_plus4_q <= '0;
         valid_q    <= 1'b0;
      end else if (load_i) begin
         instr_q    <= instr_i;
         pc_plus4_q <= pc_plus4_i;
         valid_q    <= 1'b1;
      end else if (drain_i) begin
         valid_q    <= 1'b0;
      end
   end

   assign instr_o    = instr_q;
   assign pc_plus4_o = pc_plus4_q;
   assign valid_o    = valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// MIPS IF stage plus IF/ID register with req/ready imem handshake, stall,
// branch redirect and a one-word skid for fetches that land during a stall.
// Optional feature macro: JUMP_PREDECODE_EN (zero-bubble J redirect at fetch).
module instruction_fetch
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        stall_i,
   input  logic        branchTaken_i,
   input  logic [31:0] branchTarget_i,
   output logic        imemReq_o,
   output logic [31:0] imemAddr_o,
   input  logic        imemReady_i,
   input  logic [31:0] imemData_i,
   output logic [31:0] instruction32_o,
   output logic [31:0] pcPlus4_o,
   output logic        ifidValid_o
);

   fetch_state_e state_q;
   logic [31:0]  pc_q;
   logic [31:0]  ifid_instr_q, ifid_pcp4_q;
   logic         ifid_valid_q;

   logic [31:0]  pc_plus4;
   logic [31:0]  fetch_next_pc_d;
   logic         fetch_done;
   logic         skid_load, skid_drain;
   logic [31:0]  skid_instr, skid_pcp4;
   logic         skid_valid;

   // Request is held off during reset so memory never sees a stale address.
   assign imemReq_o  = (state_q == FS_REQ) && rst_n_i;
   assign imemAddr_o = pc_q;
   assign fetch_done = imemReq_o && imemReady_i;
   assign pc_plus4   = pc_q + 32'd4;   // wraps modulo 2^32

   // Next sequential fetch address, optionally short-circuiting J at fetch.
   always_comb begin
      fetch_next_pc_d = pc_plus4;
`ifdef JUMP_PREDECODE_EN
      if (imemData_i[31:26] == OP_J)
         fetch_next_pc_d = {pc_plus4[31:28], imemData_i[25:0], 2'b00};
`endif
   end

   // Branch flush wins over everything; otherwise skid moves only on state edges.
   assign skid_load  = !branchTaken_i && (state_q == FS_REQ) && fetch_done && stall_i;
   assign skid_drain = !branchTaken_i && (state_q == FS_HOLD) && !stall_i;

   fetch_skid_buf u_skid (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .load_i     (skid_load),
      .drain_i    (skid_drain),
      .clear_i    (branchTaken_i),
      .instr_i    (imemData_i),
      .pc_plus4_i (pc_plus4),
      .instr_o    (skid_instr),
      .pc_plus4_o (skid_pcp4),
      .valid_o    (skid_valid)
   );

   // Fetch FSM: PC, state and IF/ID register.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q      <= FS_REQ;
         pc_q         <= word_align(RESET_PC);
         ifid_instr_q <= NOP_INSTR;
         ifid_pcp4_q  <= '0;
         ifid_valid_q <= 1'b0;
      end else if (branchTaken_i) begin
         // Any fetch completing this cycle belongs to the wrong path.
         state_q      <= FS_REQ;
         pc_q         <= word_align(branchTarget_i);
         ifid_instr_q <= NOP_INSTR;
         ifid_pcp4_q  <= '0;
         ifid_valid_q <= 1'b0;
      end else begin
         case (state_q)
            FS_REQ: begin
               if (fetch_done) begin
                  pc_q <= fetch_next_pc_d;
                  if (stall_i) begin
                     state_q <= FS_HOLD;
                  end else begin
                     ifid_instr_q <= imemData_i;
                     ifid_pcp4_q  <= pc_plus4;
                     ifid_valid_q <= 1'b1;
                  end
               end
            end
            FS_HOLD: begin
               if (!stall_i) begin
                  state_q      <= FS_REQ;
                  ifid_instr_q <= skid_instr;
                  ifid_pcp4_q  <= skid_pcp4;
                  ifid_valid_q <= skid_valid;
               end
            end
            default: state_q <= FS_REQ;
         endcase
      end
   end

   assign instruction32_o = ifid_valid_q ? ifid_instr_q : NOP_INSTR;
   assign pcPlus4_o       = ifid_pcp4_q;
   assign ifidValid_o     = ifid_valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: table of per-cycle vectors for the
// main instance plus a hand sequence on an instance with RESET_PC=FFFFFFFC.
module tb_instruction_fetch;

   typedef struct {
      logic        rst_n, stall, br;
      logic [31:0] tgt;
      logic        rdy;
      logic [31:0] data;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_vld;
      logic [31:0] e_instr, e_pcp4;
   } vec_t;

   localparam logic [31:0] W0 = 32'h0022_1820, W1 = 32'h0043_2020;
   localparam logic [31:0] W2 = 32'h0064_2820, W3 = 32'h0085_3020;
   localparam logic [31:0] JW = 32'h0800_0010, XX = 32'hDEAD_BEEF;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, stall, br, rdy;
   logic [31:0] tgt, data;
   logic        req, vld;
   logic [31:0] addr, instr, pcp4;

   logic        rst_n1, stall1, rdy1;
   logic [31:0] data1;
   logic        req1, vld1;
   logic [31:0] addr1, instr1, pcp41;

   int n_chk = 0, n_fail = 0;
   vec_t vq[$];

   instruction_fetch dut (
      .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .branchTaken_i(br),
      .branchTarget_i(tgt), .imemReq_o(req), .imemAddr_o(addr),
      .imemReady_i(rdy), .imemData_i(data), .instruction32_o(instr),
      .pcPlus4_o(pcp4), .ifidValid_o(vld)
   );

   instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk_i(clk), .rst_n_i(rst_n1), .stall_i(stall1), .branchTaken_i(1'b0),
      .branchTarget_i(32'h0), .imemReq_o(req1), .imemAddr_o(addr1),
      .imemReady_i(rdy1), .imemData_i(data1), .instruction32_o(instr1),
      .pcPlus4_o(pcp41), .ifidValid_o(vld1)
   );

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s [%0d]: got %h, expected %h", nm, idx, act, exp);
      end
   endtask

   task automatic add(input logic r, s, b, input logic [31:0] t, input logic y,
                      input logic [31:0] d, input logic eq, input logic [31:0] ea,
                      input logic ev, input logic [31:0] ei, ep);
      vec_t v;
      v = '{r, s, b, t, y, d, eq, ea, ev, ei, ep};
      vq.push_back(v);
   endtask

   task automatic step1(input logic r, s, y, input logic [31:0] d);
      rst_n1 = r; stall1 = s; rdy1 = y; data1 = d;
      @(posedge clk); #1;
   endtask

   logic [31:0] j_addr;

   initial begin
`ifdef JUMP_PREDECODE_EN
      j_addr = 32'h40;
`else
      j_addr = 32'h4;
`endif
      //   rst s br tgt     rdy data | req addr       vld instr pcp4
      add(0, 0, 0, 32'h0,  0, XX,     0, 32'h0,  0, 32'h0, 32'h0);  // reset
      add(1, 0, 0, 32'h0,  1, W0,     1, 32'h4,  1, W0,    32'h4);  // streaming
      add(1, 0, 0, 32'h0,  1, W1,     1, 32'h8,  1, W1,    32'h8);
      add(1, 0, 0, 32'h0,  0, XX,     1, 32'h8,  1, W1,    32'h8);  // ready low x3
      add(1, 0, 0, 32'h0,  0, XX,     1, 32'h8,  1, W1,    32'h8);
      add(1, 0, 0, 32'h0,  0, XX,     1, 32'h8,  1, W1,    32'h8);
      add(1, 0, 0, 32'h0,  1, W2,     1, 32'hC,  1, W2,    32'hC);
      add(1, 1, 0, 32'h0,  1, W3,     0, 32'h10, 1, W2,    32'hC);  // stall: W3 to skid
      add(1, 1, 0, 32'h0,  1, XX,     0, 32'h10, 1, W2,    32'hC);
      add(1, 0, 0, 32'h0,  1, XX,     1, 32'h10, 1, W3,    32'h10); // drain skid
      add(1, 0, 0, 32'h0,  1, W0,     1, 32'h14, 1, W0,    32'h14); // no dup
      add(1, 1, 1, 32'h43, 1, W1,     1, 32'h40, 0, 32'h0, 32'h0);  // branch+stall+rdy
      add(1, 0, 0, 32'h0,  1, W2,     1, 32'h44, 1, W2,    32'h44);
      add(1, 1, 0, 32'h0,  1, W3,     0, 32'h48, 1, W2,    32'h44); // HOLD w/ skid
      add(1, 1, 1, 32'h80, 0, XX,     1, 32'h80, 0, 32'h0, 32'h0);  // branch in HOLD
      add(1, 0, 0, 32'h0,  0, XX,     1, 32'h80, 0, 32'h0, 32'h0);  // skid was dropped
      add(1, 1, 0, 32'h0,  1, W0,     0, 32'h84, 0, 32'h0, 32'h0);  // HOLD again
      add(0, 1, 0, 32'h0,  0, XX,     0, 32'h0,  0, 32'h0, 32'h0);  // reset mid-HOLD
      add(1, 0, 0, 32'h0,  0, XX,     1, 32'h0,  0, 32'h0, 32'h0);  // skid gone
      add(1, 0, 0, 32'h0,  1, JW,     1, j_addr, 1, JW,    32'h4);  // J word
      add(1, 1, 0, 32'h0,  0, XX,     1, j_addr, 1, JW,    32'h4);  // stall, no fetch

      rst_n1 = 0; stall1 = 0; rdy1 = 0; data1 = '0;

      foreach (vq[i]) begin
         rst_n = vq[i].rst_n; stall = vq[i].stall; br = vq[i].br;
         tgt = vq[i].tgt; rdy = vq[i].rdy; data = vq[i].data;
         @(posedge clk); #1;
         chk("imemReq",       i, {31'b0, req}, {31'b0, vq[i].e_req});
         chk("imemAddr",      i, addr,         vq[i].e_addr);
         chk("ifidValid",     i, {31'b0, vld}, {31'b0, vq[i].e_vld});
         chk("instruction32", i, instr,        vq[i].e_instr);
         chk("pcPlus4",       i, pcp4,         vq[i].e_pcp4);
      end

      // PC wrap at the top of the address space, then reset during HOLD.
      step1(0, 0, 0, XX);
      chk("wrap_rst_addr", 0, addr1, 32'hFFFF_FFFC);
      chk("wrap_rst_req",  0, {31'b0, req1}, 32'h0);
      step1(1, 0, 1, W0);
      chk("wrap_pcp4",  1, pcp41, 32'h0);
      chk("wrap_addr",  1, addr1, 32'h0);
      chk("wrap_instr", 1, instr1, W0);
      step1(1, 1, 1, W1);
      chk("wrap_hold_req",  2, {31'b0, req1}, 32'h0);
      chk("wrap_hold_addr", 2, addr1, 32'h4);
      step1(0, 1, 0, XX);
      chk("wrap_rst_hold_addr", 3, addr1, 32'hFFFF_FFFC);
      chk("wrap_rst_hold_vld",  3, {31'b0, vld1}, 32'h0);
      step1(1, 0, 0, XX);
      chk("wrap_post_req",   4, {31'b0, req1}, 32'h1);
      chk("wrap_post_vld",   4, {31'b0, vld1}, 32'h0);
      chk("wrap_post_instr", 4, instr1, 32'h0);
      step1(1, 0, 0, XX);
      chk("wrap_post2_vld",  5, {31'b0, vld1}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
